// File: rtl/fdn_coef_sched_if.sv
// Bundle of the host coefficient stream, upstream sample stream, core-side outputs and status
// for the FDN coefficient scheduler.
interface fdn_coef_sched_if #(
   parameter int W_DATA = 25,
   parameter int W_COEF = 24
);
   logic                     coef_valid;
   logic                     coef_ready;
   logic                     coef_last;
   logic signed [W_COEF-1:0] coef_re;
   logic signed [W_COEF-1:0] coef_im;

   logic                     s_valid;
   logic                     s_ready;
   logic                     s_last;
   logic signed [W_DATA-1:0] s_re;
   logic signed [W_DATA-1:0] s_im;

   logic                     core_vld;
   logic                     core_last;
   logic signed [W_DATA-1:0] core_re;
   logic signed [W_DATA-1:0] core_im;
   logic                     core_coef_vld;
   logic signed [W_COEF-1:0] core_coef_re;
   logic signed [W_COEF-1:0] core_coef_im;

   logic                     busy;
   logic                     set_err;
   logic [15:0]              loads_done;

   modport master (
      output coef_valid, coef_last, coef_re, coef_im,
      output s_valid, s_last, s_re, s_im,
      input  coef_ready, s_ready,
      input  core_vld, core_last, core_re, core_im,
      input  core_coef_vld, core_coef_re, core_coef_im,
      input  busy, set_err, loads_done
   );

   modport slave (
      input  coef_valid, coef_last, coef_re, coef_im,
      input  s_valid, s_last, s_re, s_im,
      output coef_ready, s_ready,
      output core_vld, core_last, core_re, core_im,
      output core_coef_vld, core_coef_re, core_coef_im,
      output busy, set_err, loads_done
   );
endinterface

// File: rtl/fdn_coef_sched.sv
// Captures a host coefficient set into a shadow buffer and swaps it into the FDN core only
// between frames: wait for end of frame, let the pipeline drain, then stream the set out.
module fdn_coef_sched #(
   parameter int N_CH      = 32,
   parameter int W_DATA    = 25,
   parameter int W_COEF    = 24,
   parameter int DRAIN_CYC = 4
) (
   input logic              clk,
   input logic              rst,
   fdn_coef_sched_if.slave  bus
);
   localparam int IW = $clog2(N_CH);
   localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_CH - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {IDLE, CAPTURE, SKIP, PENDING, DRAIN, LOAD} state_t;

   state_t                   state_q, state_d;
   logic [IW-1:0]            wr_idx_q, wr_idx_d;
   logic [IW-1:0]            ld_idx_q, ld_idx_d;
   logic [DW-1:0]            drain_cnt_q, drain_cnt_d;
   logic                     in_frame_q, in_frame_d;
   logic                     set_err_q, set_err_d;
   logic [15:0]              loads_done_q, loads_done_d;
   logic                     core_vld_q, core_vld_d;
   logic                     core_last_q, core_last_d;
   logic signed [W_DATA-1:0] core_re_q, core_re_d;
   logic signed [W_DATA-1:0] core_im_q, core_im_d;
   logic                     core_coef_vld_q, core_coef_vld_d;
   logic signed [W_COEF-1:0] core_coef_re_q, core_coef_re_d;
   logic signed [W_COEF-1:0] core_coef_im_q, core_coef_im_d;

   logic [2*W_COEF-1:0]      shadow_q [N_CH];
   logic                     shadow_we;
   logic                     coef_ready, s_ready, coef_acc, s_acc;

   always_comb begin
      coef_ready = (state_q == IDLE) || (state_q == CAPTURE) || (state_q == SKIP);
      case (state_q)
         IDLE, CAPTURE, SKIP: s_ready = 1'b1;
         PENDING:             s_ready = in_frame_q;
         default:             s_ready = 1'b0;
      endcase
      coef_acc = bus.coef_valid & coef_ready;
      s_acc    = bus.s_valid & s_ready;
   end

   always_comb begin
      in_frame_d  = in_frame_q;
      core_vld_d  = s_acc;
      core_last_d = s_acc & bus.s_last;
      core_re_d   = core_re_q;
      core_im_d   = core_im_q;
      if (s_acc) begin
         in_frame_d = !bus.s_last;
         core_re_d  = bus.s_re;
         core_im_d  = bus.s_im;
      end
   end

   always_comb begin
      state_d         = state_q;
      wr_idx_d        = wr_idx_q;
      ld_idx_d        = ld_idx_q;
      drain_cnt_d     = drain_cnt_q;
      set_err_d       = 1'b0;
      loads_done_d    = loads_done_q;
      shadow_we       = 1'b0;
      core_coef_vld_d = 1'b0;
      core_coef_re_d  = '0;
      core_coef_im_d  = '0;
      case (state_q)
         IDLE, CAPTURE: begin
            if (coef_acc) begin
               shadow_we = 1'b1;
               if (bus.coef_last) begin
                  wr_idx_d = '0;
                  if (wr_idx_q == IDX_LAST) begin
                     // With no frame open the wait for end-of-frame is empty: drain at once.
                     state_d = in_frame_d ? PENDING : DRAIN;
                  end else begin
                     set_err_d = 1'b1;
                     state_d   = IDLE;
                  end
               end else if (wr_idx_q == IDX_LAST) begin
                  set_err_d = 1'b1;
                  wr_idx_d  = '0;
                  state_d   = SKIP;
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
                  state_d  = CAPTURE;
               end
            end
         end
         SKIP: begin
            if (coef_acc && bus.coef_last) state_d = IDLE;
         end
         PENDING: begin
            if (!in_frame_q || (s_acc && bus.s_last)) state_d = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               drain_cnt_d = '0;
               state_d     = LOAD;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         LOAD: begin
            core_coef_vld_d = 1'b1;
            core_coef_re_d  = shadow_q[ld_idx_q][W_COEF-1:0];
            core_coef_im_d  = shadow_q[ld_idx_q][2*W_COEF-1:W_COEF];
            if (ld_idx_q == IDX_LAST) begin
               ld_idx_d     = '0;
               loads_done_d = loads_done_q + 16'd1;
               state_d      = IDLE;
            end else begin
               ld_idx_d = ld_idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         wr_idx_q        <= '0;
         ld_idx_q        <= '0;
         drain_cnt_q     <= '0;
         in_frame_q      <= 1'b0;
         set_err_q       <= 1'b0;
         loads_done_q    <= '0;
         core_vld_q      <= 1'b0;
         core_last_q     <= 1'b0;
         core_re_q       <= '0;
         core_im_q       <= '0;
         core_coef_vld_q <= 1'b0;
         core_coef_re_q  <= '0;
         core_coef_im_q  <= '0;
      end else begin
         state_q         <= state_d;
         wr_idx_q        <= wr_idx_d;
         ld_idx_q        <= ld_idx_d;
         drain_cnt_q     <= drain_cnt_d;
         in_frame_q      <= in_frame_d;
         set_err_q       <= set_err_d;
         loads_done_q    <= loads_done_d;
         core_vld_q      <= core_vld_d;
         core_last_q     <= core_last_d;
         core_re_q       <= core_re_d;
         core_im_q       <= core_im_d;
         core_coef_vld_q <= core_coef_vld_d;
         core_coef_re_q  <= core_coef_re_d;
         core_coef_im_q  <= core_coef_im_d;
      end
   end

   // Shadow contents survive reset; only a completed set is ever streamed out.
   always_ff @(posedge clk) begin
      if (shadow_we) shadow_q[wr_idx_q] <= {bus.coef_im, bus.coef_re};
   end

   assign bus.coef_ready    = coef_ready;
   assign bus.s_ready       = s_ready;
   assign bus.core_vld      = core_vld_q;
   assign bus.core_last     = core_last_q;
   assign bus.core_re       = core_re_q;
   assign bus.core_im       = core_im_q;
   assign bus.core_coef_vld = core_coef_vld_q;
   assign bus.core_coef_re  = core_coef_re_q;
   assign bus.core_coef_im  = core_coef_im_q;
   assign bus.busy          = (state_q == PENDING) || (state_q == DRAIN) || (state_q == LOAD);
   assign bus.set_err       = set_err_q;
   assign bus.loads_done    = loads_done_q;
endmodule
